// File: rtl/mm2s_lite_regs.sv
// AXI4-Lite register file for the MM2S read-DMA channel.
// It programs DMACR/SA/SA_MSB/LENGTH, launches one datamover command per LENGTH write and tracks completion.
`timescale 1ns/1ps
module mm2s_lite_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [9:0]  s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready,
  output logic [63:0] cmd_addr,
  output logic [25:0] cmd_len,
  output logic        cmd_start,
  input  logic        cmd_done,
  output logic        mm2s_introut
);

  localparam logic [7:0] A_DMACR  = 8'h00;
  localparam logic [7:0] A_DMASR  = 8'h01;
  localparam logic [7:0] A_SA     = 8'h06;
  localparam logic [7:0] A_SA_MSB = 8'h07;
  localparam logic [7:0] A_LENGTH = 8'h0A;

  logic        aw_held_q, aw_held_d;
  logic [7:0]  awaddr_q, awaddr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rs_q, rs_d;
  logic        irqen_q, irqen_d;
  logic [31:0] sa_q, sa_d;
  logic [31:0] sa_msb_q, sa_msb_d;
  logic [25:0] length_q, length_d;
  logic        busy_q, busy_d;
  logic        idle_q, idle_d;
  logic        ioc_irq_q, ioc_irq_d;
  logic        introut_q, introut_d;
  logic        cmd_start_q, cmd_start_d;

  logic        aw_hs, w_hs, ar_hs, wr_fire, done_hit, busy_eff;
  logic [7:0]  wr_idx;
  logic [31:0] wr_data;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

  assign s_axi_lite_awready = ~aw_held_q & ~bvalid_q;
  assign s_axi_lite_wready  = ~w_held_q & ~bvalid_q;
  assign s_axi_lite_arready = ~rvalid_q;
  assign s_axi_lite_bvalid  = bvalid_q;
  assign s_axi_lite_bresp   = 2'b00;
  assign s_axi_lite_rvalid  = rvalid_q;
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = 2'b00;
  assign cmd_addr           = {sa_msb_q, sa_q};
  assign cmd_len            = length_q;
  assign cmd_start          = cmd_start_q;
  assign mm2s_introut       = introut_q;

  // Read mux samples register state as it stands at the AR handshake edge.
  always_comb begin
    rd_mux = 32'h0;
    case (s_axi_lite_araddr[9:2])
      A_DMACR:  rd_mux = {19'h0, irqen_q, 11'h0, rs_q};
      A_DMASR:  rd_mux = {19'h0, ioc_irq_q, 10'h0, idle_q, ~rs_q & ~busy_q};
      A_SA:     rd_mux = sa_q;
      A_SA_MSB: rd_mux = sa_msb_q;
      A_LENGTH: rd_mux = {6'h0, length_q};
      default:  rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    aw_held_d   = aw_held_q;
    awaddr_d    = awaddr_q;
    w_held_d    = w_held_q;
    wdata_d     = wdata_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rs_d        = rs_q;
    irqen_d     = irqen_q;
    sa_d        = sa_q;
    sa_msb_d    = sa_msb_q;
    length_d    = length_q;
    busy_d      = busy_q;
    idle_d      = idle_q;
    ioc_irq_d   = ioc_irq_q;
    introut_d   = ioc_irq_q & irqen_q;
    cmd_start_d = 1'b0;

    aw_hs   = s_axi_lite_awvalid & s_axi_lite_awready;
    w_hs    = s_axi_lite_wvalid & s_axi_lite_wready;
    ar_hs   = s_axi_lite_arvalid & s_axi_lite_arready;
    wr_idx  = aw_held_q ? awaddr_q : s_axi_lite_awaddr[9:2];
    wr_data = w_held_q ? wdata_q : s_axi_lite_wdata;
    wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs);

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_lite_awaddr[9:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_lite_wdata;
    end
    if (wr_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bvalid_q & s_axi_lite_bready) begin
      bvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q & s_axi_lite_rready) begin
      rvalid_d = 1'b0;
    end

    // Completion is applied before any write so a same-cycle LENGTH write can relaunch.
    done_hit = cmd_done & busy_q;
    busy_eff = busy_q & ~done_hit;
    if (done_hit) begin
      busy_d = 1'b0;
      idle_d = 1'b1;
    end

    if (wr_fire) begin
      case (wr_idx)
        A_DMACR: begin
          rs_d    = wr_data[0];
          irqen_d = wr_data[12];
        end
        A_DMASR: begin
          if (wr_data[12]) ioc_irq_d = 1'b0;
        end
        A_SA:     sa_d     = wr_data;
        A_SA_MSB: sa_msb_d = wr_data;
        A_LENGTH: begin
          if (!busy_eff) begin
            length_d = wr_data[25:0];
            if (rs_q && (wr_data[25:0] != 26'h0)) begin
              cmd_start_d = 1'b1;
              busy_d      = 1'b1;
              idle_d      = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    // The completion set takes priority over a simultaneous write-1-to-clear.
    if (done_hit) ioc_irq_d = 1'b1;

    if (wr_fire && (wr_idx == A_DMACR) && wr_data[2]) begin
      rs_d        = 1'b0;
      irqen_d     = 1'b0;
      sa_d        = 32'h0;
      sa_msb_d    = 32'h0;
      length_d    = 26'h0;
      busy_d      = 1'b0;
      idle_d      = 1'b0;
      ioc_irq_d   = 1'b0;
      introut_d   = 1'b0;
      cmd_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q   <= 1'b0;
      awaddr_q    <= 8'h0;
      w_held_q    <= 1'b0;
      wdata_q     <= 32'h0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      rs_q        <= 1'b0;
      irqen_q     <= 1'b0;
      sa_q        <= 32'h0;
      sa_msb_q    <= 32'h0;
      length_q    <= 26'h0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b0;
      ioc_irq_q   <= 1'b0;
      introut_q   <= 1'b0;
      cmd_start_q <= 1'b0;
    end else begin
      aw_held_q   <= aw_held_d;
      awaddr_q    <= awaddr_d;
      w_held_q    <= w_held_d;
      wdata_q     <= wdata_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rs_q        <= rs_d;
      irqen_q     <= irqen_d;
      sa_q        <= sa_d;
      sa_msb_q    <= sa_msb_d;
      length_q    <= length_d;
      busy_q      <= busy_d;
      idle_q      <= idle_d;
      ioc_irq_q   <= ioc_irq_d;
      introut_q   <= introut_d;
      cmd_start_q <= cmd_start_d;
    end
  end

endmodule
